mio_arbiter: RTL and testbench
==============================

Name: mio_arbiter

Overview:
- Shares the single memory/IO port between two masters: the multicycle CPU (port 0) and a secondary device master, such as a DMA or display fetch unit (port 1).
- Sequences every access as latch -> issue -> fixed-latency wait -> ready pulse, and returns per-master ready/rdata; cpu_ready drives the CPU's MIO_ready.
- Sits between MCPU (Addr_out/Data_out/mem_w/CPU_MIO) and the synchronous RAM/IO bus.
- Round-robin arbitration when both masters request at once.

Parameters:
MEM_LAT, 2, memory read latency in cycles after the mem_en cycle (legal 1..15)
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
cpu_req  in  1  CPU access request (CPU_MIO), level, held until cpu_ready
cpu_we  in  1  CPU write enable (mem_w)
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_ready  out  1  one-cycle completion pulse to CPU (MIO_ready)
cpu_rdata  out  DW  read data for CPU, valid when cpu_ready=1, held after
dev_req  in  1  device access request, level
dev_we  in  1  device write enable
dev_addr  in  AW  device address
dev_wdata  in  DW  device write data
dev_ready  out  1  one-cycle completion pulse to device
dev_rdata  out  DW  read data for device, valid when dev_ready=1, held after
mem_en  out  1  memory strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle
busy  out  1  1 in every state except IDLE
grant  out  1  owner of the current or last access (0=CPU, 1=device)

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Registered, Moore outputs.
- Reset (reset=0, async): state=IDLE; all ready/mem_en/mem_we=0; mem_addr/mem_wdata/rdata regs=0; cnt=0; last=1, so the CPU wins the first tie; grant=0; busy=0.
- IDLE:
  - Neither request: stay.
  - One request: grant it.
  - Both requests: grant the master != last.
  - On grant, latch addr/wdata/we of the winner into mem_* regs, set grant, go to ISSUE.
- ISSUE: mem_en=1 for exactly this cycle; mem_we=latched we; load cnt=MEM_LAT; go to WAIT.
- WAIT: mem_en=0, mem_we=0; decrement cnt; when cnt reaches 1, capture mem_rdata (reads only) into the granted master's rdata reg at the next edge and go to DONE.
  - WAIT lasts exactly MEM_LAT cycles.
- DONE: granted master's ready=1 for this single cycle; last<=grant; go to IDLE. Requests are not sampled in DONE.
- Latency: req first high in IDLE cycle N -> mem_en in N+1 -> ready in N+2+MEM_LAT (MEM_LAT=2: N+4).
- Writes use identical timing; that master's rdata is unchanged.
- Requester rule: a master deasserts req on the edge where it samples ready=1. A req still high in the IDLE cycle after DONE starts a new access.
- Req deasserted mid-access: the access completes and ready still pulses. Latched addr/data are unaffected by input changes after the grant.
- Fairness: under continuous dual requests, grants strictly alternate CPU, dev, CPU, ...
- The non-granted master's ready stays 0 and its rdata holds its value.
- reset asserted mid-access: immediate return to IDLE, no ready pulse, mem_en=0. The aborted access is not replayed.
- Out-of-range MEM_LAT is not supported; the implementation clamps it to 1 with a synthesis-time warning comment.

Test Plan:
- Reset: hold reset=0 with both reqs high -> all outputs 0, busy=0; release -> CPU granted first (grant=0), mem_en one cycle later.
- CPU read, MEM_LAT=2: cpu_req=1, cpu_addr=0x00000010, mem_rdata=0xDEADBEEF at the modelled latency -> mem_en/mem_addr=0x10 at N+1, cpu_ready=1 only at N+4, cpu_rdata=0xDEADBEEF; dev_ready stays 0.
- Device write: dev_req=1, dev_we=1, dev_addr=0x20, dev_wdata=0x12345678 -> one mem_en cycle with mem_we=1 and matching addr/data; dev_ready at N+4; dev_rdata unchanged.
- Contention: both reqs held for 4 transactions -> grants CPU, dev, CPU, dev; exactly 4 mem_en pulses; no cycle with both readys high.
- Mid-access changes: change cpu_addr to 0xFF after the grant, then drop cpu_req during WAIT -> mem_addr keeps the original value; cpu_ready still pulses once.
- Reset in WAIT: assert reset during WAIT -> state IDLE immediately, no ready pulse; after release a pending dev_req is served normally.

Source files
------------

// File: rtl/mio_arbiter.sv
// Two-master (CPU / device) arbiter for the single synchronous memory/IO port.
// Each access runs latch -> issue -> fixed-latency wait -> one-cycle ready pulse, round-robin on ties.
module mio_arbiter #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ready,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dev_req,
    input  logic          dev_we,
    input  logic [AW-1:0] dev_addr,
    input  logic [DW-1:0] dev_wdata,
    output logic          dev_ready,
    output logic [DW-1:0] dev_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant
);

    // WARNING: MEM_LAT outside 1..15 is unsupported and is clamped to 1 here.
    localparam int unsigned LAT     = (MEM_LAT >= 1 && MEM_LAT <= 15) ? MEM_LAT : 1;
    localparam logic [3:0]  LAT_CNT = 4'(LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state, state_next;
    logic [3:0] cnt;
    logic       last;
    logic       lat_we;
    logic       start;
    logic       win;

    always_comb begin
        state_next = state;
        start      = 1'b0;
        win        = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || dev_req) begin
                    start      = 1'b1;
                    win        = (cpu_req && dev_req) ? ~last : dev_req;
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = WAIT;
            WAIT:    if (cnt == 4'd1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_ready <= 1'b0;
            dev_ready <= 1'b0;
            cpu_rdata <= '0;
            dev_rdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            grant     <= 1'b0;
            last      <= 1'b1;
            lat_we    <= 1'b0;
            cnt       <= '0;
        end else begin
            busy <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        grant     <= win;
                        mem_addr  <= win ? dev_addr  : cpu_addr;
                        mem_wdata <= win ? dev_wdata : cpu_wdata;
                        lat_we    <= win ? dev_we    : cpu_we;
                        mem_we    <= win ? dev_we    : cpu_we;
                        mem_en    <= 1'b1;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    cnt    <= LAT_CNT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Read data is valid in the last WAIT cycle; ready is raised for the DONE cycle.
                    if (cnt == 4'd1) begin
                        if (grant) begin
                            dev_ready <= 1'b1;
                            if (!lat_we) dev_rdata <= mem_rdata;
                        end else begin
                            cpu_ready <= 1'b1;
                            if (!lat_we) cpu_rdata <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    cpu_ready <= 1'b0;
                    dev_ready <= 1'b0;
                    last      <= grant;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mio_arbiter.sv
// Randomized bench for mio_arbiter against a transaction-schedule model:
// each grant predicts its mem_en cycle, ready cycle and returned data from the access timing rules.
module tb_mio_arbiter;

    localparam int unsigned MEM_LAT = 2;
    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int          NCYC    = 3000;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, dev_req, dev_we;
    logic [AW-1:0] cpu_addr, dev_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dev_wdata, mem_wdata, mem_rdata;
    logic [DW-1:0] cpu_rdata, dev_rdata;
    logic          cpu_ready, dev_ready, mem_en, mem_we, busy, grant;

    always #5 clk = ~clk;

    mio_arbiter #(.MEM_LAT(MEM_LAT), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_ready(dev_ready), .dev_rdata(dev_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model state: schedule of the current access plus the values it latched.
    int            en_c, rdy_c, free_c;
    bit            owner, prev;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, rd_val, e_cpu_rd, e_dev_rd;
    int            grants_cpu, grants_dev;

    task automatic model_reset();
        en_c     = -10;
        rdy_c    = -10;
        free_c   = 0;
        owner    = 1'b0;
        prev     = 1'b1;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        e_cpu_rd = '0;
        e_dev_rd = '0;
    endtask

    initial begin
        bit w;
        reset     = 1'b0;
        cpu_req   = 1'b1;
        dev_req   = 1'b1;
        cpu_we    = 1'b0;
        dev_we    = 1'b0;
        cpu_addr  = 32'h0000_0010;
        dev_addr  = 32'h0000_0020;
        cpu_wdata = '0;
        dev_wdata = 32'h1234_5678;
        mem_rdata = '0;
        grants_cpu = 0;
        grants_dev = 0;
        model_reset();

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            if (c == rdy_c) begin
                if (!m_we) begin
                    if (owner) e_dev_rd = rd_val;
                    else       e_cpu_rd = rd_val;
                end
                prev = owner;
            end

            check("mem_en",    64'(mem_en),    64'(c == en_c));
            check("mem_we",    64'(mem_we),    64'((c == en_c) && m_we));
            check("mem_addr",  64'(mem_addr),  64'(m_addr));
            check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            check("busy",      64'(busy),      64'(c >= en_c && c <= rdy_c));
            check("grant",     64'(grant),     64'(owner));
            check("cpu_ready", 64'(cpu_ready), 64'((c == rdy_c) && !owner));
            check("dev_ready", 64'(dev_ready), 64'((c == rdy_c) && owner));
            check("cpu_rdata", 64'(cpu_rdata), 64'(e_cpu_rd));
            check("dev_rdata", 64'(dev_rdata), 64'(e_dev_rd));

            // Stimulus: reset with both requests for 3 cycles, then random traffic with rare resets.
            if (c < 3) begin
                reset   = 1'b0;
                cpu_req = 1'b1;
                dev_req = 1'b1;
            end else begin
                reset   = ($urandom_range(0, 149) != 0);
                if (c < 200) begin
                    cpu_req = 1'b1;
                    dev_req = 1'b1;
                end else begin
                    cpu_req = ($urandom_range(0, 2) != 0);
                    dev_req = ($urandom_range(0, 2) != 0);
                end
                cpu_we    = $urandom_range(0, 1);
                dev_we    = $urandom_range(0, 1);
                cpu_addr  = $urandom;
                dev_addr  = $urandom;
                cpu_wdata = $urandom;
                dev_wdata = $urandom;
            end
            if (!reset) model_reset();

            if (reset && c >= free_c && (cpu_req || dev_req)) begin
                if (cpu_req && dev_req) w = !prev;
                else                    w = dev_req;
                owner   = w;
                m_we    = w ? dev_we    : cpu_we;
                m_addr  = w ? dev_addr  : cpu_addr;
                m_wdata = w ? dev_wdata : cpu_wdata;
                rd_val  = $urandom;
                en_c    = c + 1;
                rdy_c   = c + 2 + MEM_LAT;
                free_c  = rdy_c + 1;
                if (w) grants_dev++;
                else   grants_cpu++;
            end

            // Memory returns data only in its valid cycle; any other cycle carries noise.
            if (c == en_c + MEM_LAT) mem_rdata = rd_val;
            else                     mem_rdata = $urandom;
        end

        check("cpu_granted_some", 64'(grants_cpu > 0), 64'd1);
        check("dev_granted_some", 64'(grants_dev > 0), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
